// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the M-stage access unit (master) and the memory port (slave).
// Valid/grant request channel plus a read-response channel.
interface dmem_access_unit_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// M-stage data-memory access controller: bus handshake, store lane formatting, load extension.
// Define DMEM_MISALIGN_TRAP_EN to suppress misaligned accesses and pulse MisalignM instead.
module dmem_access_unit #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWriteM,
  input  logic [1:0]          ResultSrcM,
  input  logic [2:0]          funct3M,
  input  logic [31:0]         ALUResultM,
  input  logic [31:0]         WriteDataM,
  dmem_access_unit_if.master  bus,
  output logic                StallM,
  output logic [31:0]         ReadDataM,
  output logic                MisalignM
);

  typedef enum logic [1:0] {StIdle, StResp, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_store, is_load, acc, mis, go;
  logic [1:0]  off;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [DW-1:0] rword;
  logic [31:0] rshift, load_ext;
  logic [31:0] rd_q;
  logic        capture;

  // A store wins when both store and load are flagged.
  assign is_store = MemWriteM;
  assign is_load  = ~MemWriteM & (ResultSrcM == 2'b01);
  assign acc      = is_store | is_load;
  assign off      = ALUResultM[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic half_acc, word_acc, mis_q;

  assign half_acc = (funct3M == 3'b001) | (is_load & (funct3M == 3'b101));
  assign word_acc = (funct3M == 3'b010);
  assign mis      = acc & ((half_acc & off[0]) | (word_acc & (off != 2'b00)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis & (state_q == StIdle);
  end

  assign MisalignM = mis_q;
`else
  assign mis       = 1'b0;
  assign MisalignM = 1'b0;
`endif

  assign go = acc & ~mis;

  // Store lane formatting; shifts truncate to 4 lanes so misaligned lanes drop off.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = WriteDataM;
    case (funct3M)
      3'b000: begin
        be_fmt    = 4'b0001 << off;
        wdata_fmt = {4{WriteDataM[7:0]}};
      end
      3'b001: begin
        be_fmt    = 4'b0011 << off;
        wdata_fmt = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  assign rword  = bus.mem_rdata;
  assign rshift = rword[31:0] >> {off, 3'b000};

  always_comb begin
    load_ext = rword[31:0];
    case (funct3M)
      3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_ext = {24'b0, rshift[7:0]};
      3'b101:  load_ext = {16'b0, rshift[15:0]};
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (go && bus.mem_gnt) state_d = is_store ? StDone : StResp;
      StResp: if (bus.mem_rvalid) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: bus fields are held from frozen M-stage inputs for the whole access.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = 4'b0000;
    bus.mem_wdata = '0;
    StallM        = 1'b0;
    capture       = 1'b0;
    if (go) begin
      bus.mem_req   = (state_q == StIdle);
      bus.mem_we    = is_store;
      bus.mem_addr  = AW'({ALUResultM[31:2], 2'b00});
      bus.mem_be    = is_store ? be_fmt : 4'b1111;
      bus.mem_wdata = is_store ? DW'(wdata_fmt) : '0;
      StallM        = (state_q != StDone);
    end
    capture = (state_q == StResp) & bus.mem_rvalid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rd_q <= 32'h0;
    else if (capture) rd_q <= load_ext;
  end

  assign ReadDataM = rd_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: vector table plus hand-written corner sequences.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MisalignM;

  dmem_access_unit_if #(.AW(32), .DW(32)) bus ();

  dmem_access_unit #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .bus        (bus.master),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .MisalignM  (MisalignM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        store;
    logic        both;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    funct3M    = 3'b000;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
  endtask

  // Drives one access from the IDLE cycle through DONE; returns one cycle after DONE.
  task automatic run_access(input vec_t v);
    int stalls;
    logic [31:0] exp;
    stalls     = 0;
    MemWriteM  = v.store;
    ResultSrcM = (!v.store || v.both) ? 2'b01 : 2'b00;
    funct3M    = v.f3;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    if (!v.store) exp_q.push_back(v.exp_rd);
    for (int i = 0; i <= v.gnt_dly; i++) begin
      bus.mem_gnt    = (i == v.gnt_dly);
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      if (StallM) stalls++;
      chk("req", bus.mem_req, 1'b1);
      chk("we", bus.mem_we, v.store);
      chk("addr", bus.mem_addr, {v.addr[31:2], 2'b00});
      chk("be", bus.mem_be, v.exp_be);
      if (v.store) chk("wdata", bus.mem_wdata, v.exp_wd);
      @(posedge clk); #1;
    end
    bus.mem_gnt = 1'b0;
    if (!v.store) begin
      for (int j = 1; j <= v.rv_dly; j++) begin
        bus.mem_rvalid = (j == v.rv_dly);
        bus.mem_rdata  = (j == v.rv_dly) ? v.rdata : ~v.rdata;
        @(negedge clk);
        if (StallM) stalls++;
        chk("resp_req", bus.mem_req, 1'b0);
        @(posedge clk); #1;
      end
    end
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("done_stall", StallM, 1'b0);
    chk("done_req", bus.mem_req, 1'b0);
    if (!v.store) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got empty queue want entry");
      end else begin
        exp = exp_q.pop_front();
        chk("rdata", ReadDataM, exp);
        last_rd = exp;
      end
    end else begin
      chk("rd_hold", ReadDataM, last_rd);
    end
    chk("stall_cycles", stalls, v.gnt_dly + 1 + (v.store ? 0 : v.rv_dly));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t mv;
    // store both f3 addr wdata rdata gnt rv be wd rd
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 4'b1111, 32'hDEADBEEF, 0};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h000000AB, 32'h0, 0, 0, 4'b1000, 32'hABABABAB, 0};
    vecs[2]  = '{1, 0, 3'b001, 32'h102, 32'h1234CAFE, 32'h0, 0, 0, 4'b1100, 32'hCAFECAFE, 0};
    vecs[3]  = '{0, 0, 3'b000, 32'h202, 32'h0, 32'h00800000, 0, 2, 4'b1111, 0, 32'hFFFFFF80};
    vecs[4]  = '{0, 0, 3'b100, 32'h202, 32'h0, 32'h00800000, 0, 2, 4'b1111, 0, 32'h00000080};
    vecs[5]  = '{0, 0, 3'b010, 32'h400, 32'h0, 32'h89ABCDEF, 3, 1, 4'b1111, 0, 32'h89ABCDEF};
    vecs[6]  = '{0, 0, 3'b001, 32'h002, 32'h0, 32'h80011234, 1, 1, 4'b1111, 0, 32'hFFFF8001};
    vecs[7]  = '{0, 0, 3'b101, 32'h000, 32'h0, 32'h1234F00D, 0, 3, 4'b1111, 0, 32'h0000F00D};
    vecs[8]  = '{0, 0, 3'b000, 32'h001, 32'h0, 32'h00007F00, 0, 1, 4'b1111, 0, 32'h0000007F};
    vecs[9]  = '{1, 0, 3'b000, 32'h001, 32'h00000055, 32'h0, 1, 0, 4'b0010, 32'h55555555, 0};
    vecs[10] = '{1, 0, 3'b010, 32'h7FC, 32'h01020304, 32'h0, 2, 0, 4'b1111, 32'h01020304, 0};
    vecs[11] = '{1, 1, 3'b010, 32'h010, 32'h0BADF00D, 32'h0, 0, 0, 4'b1111, 32'h0BADF00D, 0};

    last_rd        = 32'h0;
    reset          = 1'b1;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    idle_inputs();
    @(negedge clk);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_mis", MisalignM, 1'b0);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_stall", StallM, 1'b0);
    chk("rst_be", bus.mem_be, 4'b0000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back: each access starts in the IDLE cycle after the previous DONE.
    foreach (vecs[k]) run_access(vecs[k]);

    idle_inputs();
    @(negedge clk);
    chk("idle_req", bus.mem_req, 1'b0);
    chk("idle_addr", bus.mem_addr, 32'h0);
    chk("idle_wdata", bus.mem_wdata, 32'h0);
    chk("idle_stall", StallM, 1'b0);
    chk("sb_empty", exp_q.size(), 0);

    // Grant and rvalid with no access pending are ignored.
    @(posedge clk); #1;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    @(negedge clk);
    chk("stray_req", bus.mem_req, 1'b0);
    @(posedge clk); #1;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rd", ReadDataM, last_rd);
    @(posedge clk); #1;
    run_access(vecs[8]);

    // Reset while in RESP, then a late response.
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    funct3M    = 3'b010;
    ALUResultM = 32'h500;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    chk("resp_stall", StallM, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("mid_rst_rd", ReadDataM, 32'h0);
    chk("mid_rst_stall", StallM, 1'b0);
    @(posedge clk); #1;
    reset          = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h12345678;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid", ReadDataM, 32'h0);
    last_rd = 32'h0;
    @(posedge clk); #1;

`ifdef DMEM_MISALIGN_TRAP_EN
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    funct3M    = 3'b010;
    ALUResultM = 32'h301;
    @(negedge clk);
    chk("mis_req", bus.mem_req, 1'b0);
    chk("mis_stall", StallM, 1'b0);
    chk("mis_early", MisalignM, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("mis_pulse", MisalignM, 1'b1);
    chk("mis_rd", ReadDataM, last_rd);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_end", MisalignM, 1'b0);
`else
    mv = '{1, 0, 3'b001, 32'h003, 32'h0000BEEF, 32'h0, 0, 0, 4'b1000, 32'hBEEFBEEF, 0};
    run_access(mv);
    mv = '{0, 0, 3'b010, 32'h301, 32'h0, 32'hA5A55A5A, 0, 1, 4'b1111, 0, 32'hA5A55A5A};
    run_access(mv);
    @(negedge clk);
    chk("mis_tied", MisalignM, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
